// File: rtl/mem_arbiter.sv
// Single-port main-memory arbiter for icache refills and dcache refills/writebacks.
// One line transfer at a time; dcache has priority but alternates with icache so fetch cannot starve.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ic_read_req,
   input  logic [ADDR_W-1:0] ic_read_addr,
   output logic [LINE_W-1:0] ic_read_data,
   output logic              ic_read_ack,
   input  logic              dc_read_req,
   input  logic [ADDR_W-1:0] dc_read_addr,
   output logic [LINE_W-1:0] dc_read_data,
   output logic              dc_read_ack,
   input  logic              dc_write_req,
   input  logic [ADDR_W-1:0] dc_write_addr,
   input  logic [LINE_W-1:0] dc_write_data,
   output logic              dc_write_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;
   typedef enum logic [1:0] {G_IC, G_DRD, G_DWR} grant_e;

   state_e              state_q, state_d;
   grant_e              grant_q, grant_d;
   logic                last_dc_q, last_dc_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [LINE_W-1:0]   ic_data_q, ic_data_d;
   logic [LINE_W-1:0]   dc_data_q, dc_data_d;
   logic                ic_ack_q, ic_ack_d;
   logic                dc_rd_ack_q, dc_rd_ack_d;
   logic                dc_wr_ack_q, dc_wr_ack_d;

   logic dc_any;
   logic ic_wins;

   assign dc_any  = dc_write_req | dc_read_req;
   // Icache takes its turn right after a dcache grant, or whenever dcache is silent.
   assign ic_wins = ic_read_req & (last_dc_q | ~dc_any);

   // NOTE: every signal gets its default before the case so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_dc_d   = last_dc_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      ic_data_d   = ic_data_q;
      dc_data_d   = dc_data_q;
      ic_ack_d    = 1'b0;
      dc_rd_ack_d = 1'b0;
      dc_wr_ack_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (ic_wins) begin
               grant_d    = G_IC;
               last_dc_d  = 1'b0;
               mem_we_d   = 1'b0;
               mem_addr_d = ic_read_addr;
               mem_req_d  = 1'b1;
               state_d    = S_BUSY;
            end else if (dc_write_req) begin
               grant_d     = G_DWR;
               last_dc_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = dc_write_addr;
               mem_wdata_d = dc_write_data;
               mem_req_d   = 1'b1;
               state_d     = S_BUSY;
            end else if (dc_read_req) begin
               grant_d    = G_DRD;
               last_dc_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = dc_read_addr;
               mem_req_d  = 1'b1;
               state_d    = S_BUSY;
            end
         end
         S_BUSY: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = S_RESP;
               unique case (grant_q)
                  G_IC: begin
                     ic_data_d = mem_rdata;
                     ic_ack_d  = 1'b1;
                  end
                  G_DRD: begin
                     dc_data_d   = mem_rdata;
                     dc_rd_ack_d = 1'b1;
                  end
                  default: dc_wr_ack_d = 1'b1;
               endcase
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state is updated only with non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         grant_q     <= G_IC;
         last_dc_q   <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         ic_data_q   <= '0;
         dc_data_q   <= '0;
         ic_ack_q    <= 1'b0;
         dc_rd_ack_q <= 1'b0;
         dc_wr_ack_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_dc_q   <= last_dc_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         ic_data_q   <= ic_data_d;
         dc_data_q   <= dc_data_d;
         ic_ack_q    <= ic_ack_d;
         dc_rd_ack_q <= dc_rd_ack_d;
         dc_wr_ack_q <= dc_wr_ack_d;
      end
   end

   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign ic_read_data = ic_data_q;
   assign dc_read_data = dc_data_q;
   assign ic_read_ack  = ic_ack_q;
   assign dc_read_ack  = dc_rd_ack_q;
   assign dc_write_ack = dc_wr_ack_q;

endmodule
